// File: rtl/clock_div_pkg.sv
// Shared limits and debug types for the power-of-two clock divider.
package clock_div_pkg;

   localparam int CLK_DIV_N_MIN = 1;
   localparam int CLK_DIV_N_MAX = 16;

   // Widest possible counter image, for debug taps and coverage.
   typedef logic [CLK_DIV_N_MAX-1:0] clk_div_cnt_t;

endpackage : clock_div_pkg

// File: rtl/global_if.sv
// Global control bundle (reset, sleep) distributed to every block in the design.
interface global_if;

   logic reset;
   logic sleep;

   modport dut (input reset, input sleep);
   modport tb  (output reset, output sleep);

endinterface : global_if

// File: rtl/clock_divider.sv
// Power-of-two clock divider: clk_out is the MSB of a free-running N-bit counter.
// Define CLOCK_DIVIDER_SLEEP_EN to build in the synchronous sleep clear/hold.
module clock_divider
   import clock_div_pkg::*;
#(
   parameter int N = 1
) (
   input  logic      clk_in,
   global_if.dut     glb,
   output logic      clk_out
);

   if (N < CLK_DIV_N_MIN || N > CLK_DIV_N_MAX) begin : g_bad_n
      $fatal(1, "clock_divider: N=%0d outside legal range", N);
   end

   logic [N-1:0] cnt_q;
   logic [N-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + N'(1);
`ifdef CLOCK_DIVIDER_SLEEP_EN
      // Sleep restarts from zero so the wake-up phase matches reset release.
      if (glb.sleep == 1'b1) begin
         cnt_d = '0;
      end
`endif
   end

   always_ff @(posedge clk_in or posedge glb.reset) begin
      if (glb.reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign clk_out = cnt_q[N-1];

endmodule : clock_divider

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: N = 1, 6, 7, 8 side by side on one global_if.
`timescale 1ns/1ps
module tb_clock_divider;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   global_if gif ();

   logic out1, out6, out7, out8;

   clock_divider #(.N(1)) u_div1 (.clk_in(clk_in), .glb(gif), .clk_out(out1));
   clock_divider #(.N(6)) u_div6 (.clk_in(clk_in), .glb(gif), .clk_out(out6));
   clock_divider #(.N(7)) u_div7 (.clk_in(clk_in), .glb(gif), .clk_out(out7));
   clock_divider #(.N(8)) u_div8 (.clk_in(clk_in), .glb(gif), .clk_out(out8));

   // Expected-vector bit order is {N=8, N=7, N=6, N=1}.
   typedef struct {
      string      name;
      logic [3:0] mask;
      logic [3:0] expv;
   } exp_t;

   typedef struct {
      int         e;
      logic [3:0] v;
   } tbl_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ecount = 0;
   int   nval[4] = '{1, 6, 7, 8};

   // Hand-derived waveform landmarks after a common reset release.
   tbl_t tbl[10] = '{
      '{31,  4'b0000}, '{32,  4'b0010}, '{63,  4'b0010}, '{64,  4'b0100},
      '{96,  4'b0110}, '{127, 4'b0110}, '{128, 4'b1000}, '{192, 4'b1100},
      '{255, 4'b1110}, '{256, 4'b0000}
   };

   // High for the second half of every 2^n-edge period, counting from release.
   function automatic logic refBit(input int e, input int n);
      return (e % (1 << n)) >= (1 << (n - 1));
   endfunction

   function automatic logic [3:0] refVec(input int e);
      return {refBit(e, 8), refBit(e, 7), refBit(e, 6), refBit(e, 1)};
   endfunction

   task automatic checkOutput(input string name, input logic [3:0] mask, input logic [3:0] expv);
      logic [3:0] act;
      act = {out8, out7, out6, out1};
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            checks++;
            if (act[i] !== expv[i]) begin
               errors++;
               $display("[TB] FAIL %s N=%0d edge=%0d clk_out=%b expected=%b",
                        name, nval[i], ecount, act[i], expv[i]);
            end
         end
      end
   endtask

   // Advance n rising edges, pushing the expected outputs for each edge.
   task automatic applyStimulus(input int n, input string name, input bit use_tbl);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_in);
         if (gif.reset) begin
            ecount = 0;
`ifdef CLOCK_DIVIDER_SLEEP_EN
         end else if (gif.sleep) begin
            ecount = 0;
`endif
         end else begin
            ecount++;
         end
         sb_q.push_back('{name, 4'b1111, refVec(ecount)});
         if (use_tbl) begin
            for (int t = 0; t < 10; t++) begin
               if (tbl[t].e == ecount) begin
                  sb_q.push_back('{"landmark", 4'b1110, tbl[t].v});
               end
            end
         end
      end
   endtask

   always @(negedge clk_in) begin
      while (sb_q.size() > 0) begin
         exp_t item;
         item = sb_q.pop_front();
         checkOutput(item.name, item.mask, item.expv);
      end
   end

   initial begin
      gif.reset = 1'b1;
      gif.sleep = 1'b0;
      #1;
      checkOutput("reset_state", 4'b1111, 4'b0000);

      // Reset held for 3 us, then common release.
      applyStimulus(300, "reset_hold", 1'b0);
      @(negedge clk_in);
      gif.reset = 1'b0;
      applyStimulus(260, "common_run", 1'b1);

      // Fresh reset, run N=6 into its high phase, then reset asynchronously.
      @(negedge clk_in);
      gif.reset = 1'b1;
      applyStimulus(3, "reset2", 1'b0);
      @(negedge clk_in);
      gif.reset = 1'b0;
      applyStimulus(40, "pre_async", 1'b0);
      @(negedge clk_in);
      #1;
      gif.reset = 1'b1;
      #1;
      ecount = 0;
      checkOutput("async_reset", 4'b1111, 4'b0000);
      applyStimulus(2, "async_hold", 1'b0);
      @(negedge clk_in);
      gif.reset = 1'b0;
      applyStimulus(40, "after_async", 1'b0);

      // Sleep scenario: asserted after edge 70, held 20 edges, then released.
      @(negedge clk_in);
      gif.reset = 1'b1;
      applyStimulus(2, "reset3", 1'b0);
      @(negedge clk_in);
      gif.reset = 1'b0;
      applyStimulus(70, "pre_sleep", 1'b0);
      @(negedge clk_in);
      gif.sleep = 1'b1;
      applyStimulus(10, "sleep", 1'b0);
`ifndef CLOCK_DIVIDER_SLEEP_EN
      @(negedge clk_in);
      gif.sleep = 1'bx;
`endif
      applyStimulus(10, "sleep_late", 1'b0);
      @(negedge clk_in);
      gif.sleep = 1'b0;
      applyStimulus(70, "post_sleep", 1'b0);

      repeat (3) @(negedge clk_in);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain pending=%0d expected=0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_clock_divider
